// File: rtl/fft_symbol_sched_if.sv
// fft_symbol_sched_if: sample stream, FFT core side-band and output bin bus of the symbol sequencer
//   i_valid/o_ready/i_data/i_sym_start/i_cp_long : OFDM input stream
//   o_fft_ce/o_fft_sample/i_fft_result/i_fft_sync : FFT core connection
//   o_valid/o_data/o_first/o_last/o_sym_idx       : tagged output bins
//   o_sym_err/o_sync_err                          : error pulses
interface fft_symbol_sched_if #(
  parameter int IWIDTH = 16,
  parameter int OWIDTH = 21,
  parameter int SYMW   = 4
);
  logic                i_valid;
  logic                o_ready;
  logic [2*IWIDTH-1:0] i_data;
  logic                i_sym_start;
  logic                i_cp_long;
  logic                o_fft_ce;
  logic [2*IWIDTH-1:0] o_fft_sample;
  logic [2*OWIDTH-1:0] i_fft_result;
  logic                i_fft_sync;
  logic                o_valid;
  logic [2*OWIDTH-1:0] o_data;
  logic                o_first;
  logic                o_last;
  logic [SYMW-1:0]     o_sym_idx;
  logic                o_sym_err;
  logic                o_sync_err;
  modport slave (
    input  i_valid, i_data, i_sym_start, i_cp_long, i_fft_result, i_fft_sync,
    output o_ready, o_fft_ce, o_fft_sample, o_valid, o_data, o_first, o_last, o_sym_idx, o_sym_err, o_sync_err
  );
  modport master (
    output i_valid, i_data, i_sym_start, i_cp_long, i_fft_result, i_fft_sync,
    input  o_ready, o_fft_ce, o_fft_sample, o_valid, o_data, o_first, o_last, o_sym_idx, o_sym_err, o_sync_err
  );
endinterface

// File: rtl/fft_symbol_sched.sv
// fft_symbol_sched: strips the cyclic prefix, feeds NFFT samples per symbol to the FFT core, flushes on idle, tags outputs
//   i_clk, i_reset : clock, asynchronous active-high reset
//   bus (slave)    : input stream, FFT core ce/sample/result/sync, output bins, error pulses
module fft_symbol_sched #(
  parameter int NFFT        = 256,
  parameter int LGNFFT      = 8,
  parameter int IWIDTH      = 16,
  parameter int OWIDTH      = 21,
  parameter int CP_LEN      = 18,
  parameter int CP_LEN_LONG = 20,
  parameter int FLUSH_TMO   = 64,
  parameter int LGDEPTH     = 2,
  parameter int SYMW        = 4
) (
  input logic               i_clk,
  input logic               i_reset,
  fft_symbol_sched_if.slave bus
);
  localparam int DEPTH = 1 << LGDEPTH;
  localparam int CPW   = $clog2(CP_LEN_LONG + 1);
  localparam int TW    = $clog2(FLUSH_TMO + 1);
  localparam logic [LGNFFT-1:0] LAST = LGNFFT'(NFFT - 1);
  typedef enum logic [1:0] {WAIT, CP, DATA, FLUSH} state_t;
  state_t r_state, w_next;
  logic [CPW-1:0]      r_cp_cnt, r_cp_len;
  logic [LGNFFT-1:0]   r_d_cnt, r_out_cnt, w_cnt_inc, w_cnt;
  logic [TW-1:0]       r_idle;
  logic [SYMW-1:0]     r_sym_idx, r_osym;
  logic [LGDEPTH:0]    r_wr, r_rd, w_count;
  logic                r_tag_real [DEPTH];
  logic [SYMW-1:0]     r_tag_idx [DEPTH];
  logic                r_fft_ce, r_ce_d, r_out_locked, r_valid, r_first, r_last, r_sym_err, r_sync_err;
  logic [2*IWIDTH-1:0] r_fft_sample;
  logic [2*OWIDTH-1:0] r_data;
  logic                w_ready, w_acc, w_ce, w_frame_end, w_push, w_push_real;
  logic                w_full, w_empty, w_has_real, w_head_real, w_lock, w_pop, w_push_ok;
  always_comb begin
    w_count = r_wr - r_rd;
    w_full = w_count == (LGDEPTH+1)'(DEPTH);
    w_empty = w_count == '0;
    w_head_real = !w_empty && r_tag_real[r_rd[LGDEPTH-1:0]];
    w_has_real = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      if ((LGDEPTH+1)'(k) < w_count && r_tag_real[r_rd[LGDEPTH-1:0] + LGDEPTH'(k)]) w_has_real = 1'b1;
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_state <= WAIT;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT:  if (w_acc && bus.i_sym_start) w_next = CP;
             else if (r_idle == TW'(FLUSH_TMO) && w_has_real) w_next = FLUSH;
      CP:    if (w_acc && r_cp_cnt + 1'b1 == r_cp_len) w_next = DATA;
      DATA:  if (w_acc && r_d_cnt == LAST) w_next = WAIT;
      FLUSH: if (r_d_cnt == LAST && !w_has_real) w_next = WAIT;
    endcase
  end
  always_comb begin
    w_ready = !i_reset && r_state != FLUSH;
    w_acc = bus.i_valid && w_ready;
    w_ce = (r_state == DATA && w_acc) || r_state == FLUSH;
    w_frame_end = w_ce && r_d_cnt == LAST;
    w_push = w_frame_end;
    w_push_real = r_state == DATA;
  end
  // the core result for a ce is visible in the following (ce_d) cycle
  always_comb begin
    w_cnt_inc = r_out_cnt + 1'b1;
    w_cnt = bus.i_fft_sync ? '0 : w_cnt_inc;
    w_lock = r_out_locked || bus.i_fft_sync;
    w_pop = r_ce_d && w_lock && w_cnt == LAST && !w_empty;
    w_push_ok = w_push && (!w_full || w_pop);
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_cp_cnt <= '0;
      r_cp_len <= '0;
      r_d_cnt <= '0;
      r_idle <= '0;
      r_sym_idx <= '0;
      r_wr <= '0;
      r_rd <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_tag_real[k] <= 1'b0;
        r_tag_idx[k] <= '0;
      end
      r_fft_ce <= 1'b0;
      r_fft_sample <= '0;
      r_ce_d <= 1'b0;
      r_out_locked <= 1'b0;
      r_out_cnt <= '0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last <= 1'b0;
      r_data <= '0;
      r_osym <= '0;
      r_sym_err <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_idle <= (w_acc || r_state == FLUSH) ? '0 : r_idle == TW'(FLUSH_TMO) ? r_idle : r_idle + 1'b1;
      if (r_state == WAIT && w_acc && bus.i_sym_start) begin
        r_cp_len <= bus.i_cp_long ? CPW'(CP_LEN_LONG) : CPW'(CP_LEN);
        r_cp_cnt <= CPW'(1);
      end else if (r_state == CP && w_acc) r_cp_cnt <= r_cp_cnt + 1'b1;
      r_d_cnt <= r_state == WAIT ? '0 : w_ce ? r_d_cnt + 1'b1 : r_d_cnt;
      r_fft_ce <= w_ce;
      if (w_ce) r_fft_sample <= r_state == FLUSH ? '0 : bus.i_data;
      r_ce_d <= r_fft_ce;
      if (w_frame_end && r_state == DATA) r_sym_idx <= r_sym_idx + 1'b1;
      if (w_push_ok) begin
        r_tag_real[r_wr[LGDEPTH-1:0]] <= w_push_real;
        r_tag_idx[r_wr[LGDEPTH-1:0]] <= r_sym_idx;
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_sym_err <= w_acc && bus.i_sym_start && r_state != WAIT;
      r_sync_err <= (r_ce_d && bus.i_fft_sync && r_out_locked && w_cnt_inc != '0) || (w_push && !w_push_ok);
      if (r_ce_d) begin
        r_out_locked <= w_lock;
        if (w_lock) r_out_cnt <= w_cnt;
        r_data <= bus.i_fft_result;
        r_osym <= r_tag_idx[r_rd[LGDEPTH-1:0]];
      end
      r_valid <= r_ce_d && w_lock && w_head_real;
      r_first <= r_ce_d && w_lock && w_head_real && w_cnt == '0;
      r_last <= r_ce_d && w_lock && w_head_real && w_cnt == LAST;
    end
  assign bus.o_ready = w_ready;
  assign bus.o_fft_ce = r_fft_ce;
  assign bus.o_fft_sample = r_fft_sample;
  assign bus.o_valid = r_valid;
  assign bus.o_data = r_data;
  assign bus.o_first = r_first;
  assign bus.o_last = r_last;
  assign bus.o_sym_idx = r_osym;
  assign bus.o_sym_err = r_sym_err;
  assign bus.o_sync_err = r_sync_err;
endmodule

// File: tb/tb_fft_symbol_sched.sv
// tb_fft_symbol_sched: scoreboard bench for fft_symbol_sched with a fixed-latency model of the FFT core
module tb_fft_symbol_sched;
  localparam int NFFT = 256;
  localparam int IW   = 16;
  localparam int OW   = 21;
  localparam int SYMW = 4;
  localparam int LAT  = 266;
  typedef struct {
    logic [2*OW-1:0] data;
    logic [SYMW-1:0] idx;
    logic            first;
    logic            last;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fft_symbol_sched_if #(.IWIDTH(IW), .OWIDTH(OW), .SYMW(SYMW)) bus();
  fft_symbol_sched dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   tb_sym = 0;
  bit   mon_en = 1'b1;
  int   inj_req = 0;
  function automatic logic [2*OW-1:0] ext(input logic [2*IW-1:0] s);
    return {{(OW-IW){s[2*IW-1]}}, s[2*IW-1:IW], {(OW-IW){s[IW-1]}}, s[IW-1:0]};
  endfunction
  // core model: output of ce n is the sample of ce n-LAT, sync on every NFFT-th output
  logic [2*IW-1:0] pipe[$];
  logic [2*IW-1:0] old_s;
  int ce_n = 0;
  int inj_ack = 0;
  always @(posedge clk or posedge rst)
    if (rst) begin
      pipe.delete();
      ce_n = 0;
      inj_ack = inj_req;
      bus.i_fft_result <= '0;
      bus.i_fft_sync <= 1'b0;
    end else if (bus.o_fft_ce) begin
      pipe.push_back(bus.o_fft_sample);
      if (pipe.size() > LAT) begin
        old_s = pipe.pop_front();
        bus.i_fft_result <= ext(old_s);
      end
      bus.i_fft_sync <= (ce_n >= LAT && (ce_n - LAT) % NFFT == 0) || inj_req != inj_ack;
      inj_ack = inj_req;
      ce_n++;
    end
  int n_ce = 0, n_valid = 0, n_first = 0, n_last = 0, n_syme = 0, n_synce = 0, n_nordy = 0;
  always @(negedge clk)
    if (!rst) begin
      n_ce += int'(bus.o_fft_ce);
      n_valid += int'(bus.o_valid);
      n_first += int'(bus.o_first);
      n_last += int'(bus.o_last);
      n_syme += int'(bus.o_sym_err);
      n_synce += int'(bus.o_sync_err);
      n_nordy += int'(!bus.o_ready);
    end
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && bus.o_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL out_extra: o_valid=1 data=%h, required no output", bus.o_data);
        end else begin
          e = sb.pop_front();
          if ({bus.o_data, bus.o_sym_idx, bus.o_first, bus.o_last} !== {e.data, e.idx, e.first, e.last}) begin
            n_fail++;
            $display("FAIL out_bin: data=%h idx=%0d first=%b last=%b, required data=%h idx=%0d first=%b last=%b",
                     bus.o_data, bus.o_sym_idx, bus.o_first, bus.o_last, e.data, e.idx, e.first, e.last);
          end
        end
      end
    end
  endtask
  task automatic drive(input logic [2*IW-1:0] d, input bit st, input bit lng);
    int t = 0;
    @(negedge clk);
    while (!bus.o_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.o_ready) begin
      n_fail++;
      $display("FAIL ready_timeout: o_ready=%b, required 1", bus.o_ready);
      $fatal(1, "o_ready stuck low");
    end
    bus.i_valid = 1'b1;
    bus.i_data = d;
    bus.i_sym_start = st;
    bus.i_cp_long = lng;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_sym_start = 1'b0;
    bus.i_cp_long = 1'b0;
  endtask
  // kind: 0 random data, 1 impulse at sample 0; err_at/inj_at: data index for a stray start / forced sync, -1 for none
  task automatic send_symbol(input bit lng, input bit gaps, input int kind, input int ndata, input int err_at, input int inj_at);
    logic [2*IW-1:0] d;
    int cpl;
    cpl = lng ? 20 : 18;
    for (int i = 0; i < cpl; i++) begin
      if (gaps) while ($urandom_range(1) == 1) @(negedge clk);
      drive($urandom, i == 0, lng);
    end
    for (int i = 0; i < ndata; i++) begin
      if (gaps) while ($urandom_range(1) == 1) @(negedge clk);
      d = kind == 1 ? (i == 0 ? 32'h1000_0000 : 32'h0) : $urandom;
      sb.push_back('{ext(d), SYMW'(tb_sym), i == 0, i == NFFT-1});
      if (i == inj_at) inj_req++;
      drive(d, i == err_at, 1'b0);
    end
    tb_sym++;
  endtask
  task automatic wait_drain();
    int t = 0;
    while (!(sb.size() == 0 && bus.o_ready) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (sb.size() != 0 || !bus.o_ready) begin
      n_fail++;
      $display("FAIL drain: pending=%0d o_ready=%b, required pending=0 o_ready=1", sb.size(), bus.o_ready);
    end
    repeat (4) @(negedge clk);
  endtask
  task automatic test_reset();
    int v0, f0, l0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.o_valid, bus.o_fft_ce, bus.o_first, bus.o_last, bus.o_sym_err, bus.o_sync_err, bus.o_ready, bus.o_sym_idx, bus.o_data, bus.o_fft_sample} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b ce=%b ready=%b data=%h, required all 0", bus.o_valid, bus.o_fft_ce, bus.o_ready, bus.o_data);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: o_ready=%b, required 1", bus.o_ready);
    end
    send_symbol(1'b0, 1'b0, 0, 100, -1, -1);
    n_checks++;
    if (bus.o_fft_ce !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_data_ce: o_fft_ce=%b, required 1", bus.o_fft_ce);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.o_valid, bus.o_fft_ce, bus.o_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_async: valid=%b ce=%b ready=%b, required 000", bus.o_valid, bus.o_fft_ce, bus.o_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    tb_sym = 0;
    v0 = n_valid; f0 = n_first; l0 = n_last;
    send_symbol(1'b0, 1'b0, 0, NFFT, -1, -1);
    wait_drain();
    n_checks++;
    if (n_valid - v0 != NFFT || n_first - f0 != 1 || n_last - l0 != 1) begin
      n_fail++;
      $display("FAIL reset_frame: valid=%0d first=%0d last=%0d, required 256 1 1", n_valid - v0, n_first - f0, n_last - l0);
    end
  endtask
  task automatic test_single();
    int c0, r0, v0, f0, l0;
    c0 = n_ce; r0 = n_nordy; v0 = n_valid; f0 = n_first; l0 = n_last;
    send_symbol(1'b0, 1'b0, 1, NFFT, -1, -1);
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (n_ce - c0 != NFFT) begin
      n_fail++;
      $display("FAIL single_ce: ce=%0d, required 256", n_ce - c0);
    end
    wait_drain();
    n_checks++;
    if (n_nordy - r0 != 2*NFFT) begin
      n_fail++;
      $display("FAIL flush_len: not_ready=%0d, required 512", n_nordy - r0);
    end
    n_checks++;
    if (n_valid - v0 != NFFT || n_first - f0 != 1 || n_last - l0 != 1) begin
      n_fail++;
      $display("FAIL single_frame: valid=%0d first=%0d last=%0d, required 256 1 1", n_valid - v0, n_first - f0, n_last - l0);
    end
  endtask
  task automatic test_back_to_back();
    int r0, v0, f0, l0;
    r0 = n_nordy; v0 = n_valid; f0 = n_first; l0 = n_last;
    send_symbol(1'b1, 1'b0, 0, NFFT, -1, -1);
    send_symbol(1'b0, 1'b0, 0, NFFT, -1, -1);
    send_symbol(1'b0, 1'b0, 0, NFFT, -1, -1);
    @(negedge clk);
    #1;
    n_checks++;
    if (n_nordy != r0) begin
      n_fail++;
      $display("FAIL b2b_no_flush: not_ready=%0d, required 0", n_nordy - r0);
    end
    wait_drain();
    n_checks++;
    if (n_valid - v0 != 3*NFFT || n_first - f0 != 3 || n_last - l0 != 3) begin
      n_fail++;
      $display("FAIL b2b_frames: valid=%0d first=%0d last=%0d, required 768 3 3", n_valid - v0, n_first - f0, n_last - l0);
    end
  endtask
  task automatic test_gaps();
    int c0, v0;
    c0 = n_ce; v0 = n_valid;
    send_symbol(1'b0, 1'b1, 0, NFFT, -1, -1);
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (n_ce - c0 != NFFT) begin
      n_fail++;
      $display("FAIL gaps_ce: ce=%0d, required 256", n_ce - c0);
    end
    wait_drain();
    n_checks++;
    if (n_valid - v0 != NFFT) begin
      n_fail++;
      $display("FAIL gaps_frame: valid=%0d, required 256", n_valid - v0);
    end
  endtask
  task automatic test_sym_err();
    int s0, y0, v0;
    s0 = n_syme; y0 = n_synce; v0 = n_valid;
    send_symbol(1'b0, 1'b0, 0, NFFT, 100, -1);
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (n_syme - s0 != 1) begin
      n_fail++;
      $display("FAIL sym_err_pulse: pulses=%0d, required 1", n_syme - s0);
    end
    wait_drain();
    n_checks++;
    if (n_valid - v0 != NFFT || n_synce != y0) begin
      n_fail++;
      $display("FAIL sym_err_frame: valid=%0d sync_err=%0d, required 256 0", n_valid - v0, n_synce - y0);
    end
  endtask
  task automatic test_sync_err();
    int t;
    mon_en = 1'b0;
    fork
      begin
        send_symbol(1'b0, 1'b0, 0, NFFT, -1, -1);
        send_symbol(1'b0, 1'b0, 0, NFFT, -1, 50);
      end
      begin
        t = 0;
        while (!bus.o_sync_err && t < 3000) begin
          @(negedge clk);
          t++;
        end
        n_checks++;
        if ({bus.o_sync_err, bus.o_valid, bus.o_first} !== 3'b111) begin
          n_fail++;
          $display("FAIL sync_err: sync_err=%b valid=%b first=%b, required 111", bus.o_sync_err, bus.o_valid, bus.o_first);
        end
      end
    join
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    tb_sym = 0;
    mon_en = 1'b1;
  endtask
  initial begin
    bus.i_valid = 1'b0;
    bus.i_data = '0;
    bus.i_sym_start = 1'b0;
    bus.i_cp_long = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_gaps();
    test_sym_err();
    test_sync_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
